// File: rtl/cache_wb_param.sv
// Direct-mapped write-back, write-allocate data cache with burst refill/write-back.
// Optional hit/miss counters when CACHE_STATS_EN is defined.
module cache_wb_param #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int LINES          = 256,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              write_en_in,
   input  logic [ADDR_W-1:0] address_input,
   input  logic [DATA_W-1:0] read_data_2,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] read_data,
   output logic              hit,
   output logic              cache_done,
   output logic              mem_req,
   output logic              write_en_out,
   output logic [ADDR_W-1:0] address_output,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
`ifdef CACHE_STATS_EN
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count,
`endif
   input  logic              mem_ready
);

   localparam int OFF_W = $clog2(WORDS_PER_LINE);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
   localparam int WA_W  = ADDR_W - 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COMPARE,
      S_WRITEBACK,
      S_REFILL,
      S_RESPOND
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [OFF_W-1:0]    r_beat;
   logic [OFF_W-1:0]    w_beat_nxt;

   logic [DATA_W-1:0]   r_data [LINES*WORDS_PER_LINE];
   logic [TAG_W-1:0]    r_tag  [LINES];
   logic [LINES-1:0]    r_valid;
   logic [LINES-1:0]    r_dirty;

   logic [WA_W-1:0]     r_waddr;
   logic                r_we;
   logic [DATA_W-1:0]   r_wdata;

   logic [OFF_W-1:0]    w_off;
   logic [IDX_W-1:0]    w_idx;
   logic [TAG_W-1:0]    w_tag;
   logic [TAG_W-1:0]    w_line_tag;
   logic                w_hit;
   logic                w_victim_dirty;
   logic                w_last;
   logic [DATA_W-1:0]   w_word;
   logic [DATA_W-1:0]   w_vword;

   logic                w_we;
   logic [IDX_W+OFF_W-1:0] w_widx;
   logic [DATA_W-1:0]   w_wdata;
   logic                w_mark_dirty;
   logic                w_fill;
   logic                w_unused;

   assign w_unused       = ^address_input[1:0];
   assign w_off          = r_waddr[OFF_W-1:0];
   assign w_idx          = r_waddr[OFF_W +: IDX_W];
   assign w_tag          = r_waddr[WA_W-1 -: TAG_W];
   assign w_line_tag     = r_tag[w_idx];
   assign w_hit          = r_valid[w_idx] && (w_line_tag == w_tag);
   assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
   assign w_last         = (r_beat == OFF_W'(WORDS_PER_LINE - 1));
   assign w_word         = r_data[{w_idx, w_off}];
   assign w_vword        = r_data[{w_idx, r_beat}];

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_beat  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_beat_nxt     = r_beat;
      w_we           = 1'b0;
      w_widx         = {w_idx, w_off};
      w_wdata        = r_wdata;
      w_mark_dirty   = 1'b0;
      w_fill         = 1'b0;
      cpu_ready      = 1'b0;
      read_data      = '0;
      hit            = 1'b0;
      cache_done     = 1'b0;
      mem_req        = 1'b0;
      write_en_out   = 1'b0;
      address_output = '0;
      mem_data_in    = '0;
      unique case (r_state)
         S_IDLE: begin
            cpu_ready = 1'b1;
            if (cpu_req) w_state_nxt = S_COMPARE;
         end
         S_COMPARE: begin
            if (w_hit) begin
               cache_done   = 1'b1;
               hit          = 1'b1;
               read_data    = w_word;
               w_we         = r_we;
               w_mark_dirty = r_we;
               w_state_nxt  = S_IDLE;
            end else if (w_victim_dirty) begin
               w_state_nxt = S_WRITEBACK;
            end else begin
               w_state_nxt = S_REFILL;
            end
         end
         S_WRITEBACK: begin
            mem_req        = 1'b1;
            write_en_out   = 1'b1;
            address_output = {w_line_tag, w_idx, r_beat, 2'b00};
            mem_data_in    = w_vword;
            if (mem_ready) begin
               w_beat_nxt = r_beat + OFF_W'(1);
               if (w_last) w_state_nxt = S_REFILL;
            end
         end
         S_REFILL: begin
            mem_req        = 1'b1;
            address_output = {w_tag, w_idx, r_beat, 2'b00};
            if (mem_ready) begin
               w_we       = 1'b1;
               w_widx     = {w_idx, r_beat};
               w_wdata    = mem_data_out;
               w_beat_nxt = r_beat + OFF_W'(1);
               if (w_last) begin
                  w_fill      = 1'b1;
                  w_state_nxt = S_RESPOND;
               end
            end
         end
         S_RESPOND: begin
            cache_done   = 1'b1;
            read_data    = w_word;
            w_we         = r_we;
            w_mark_dirty = r_we;
            w_state_nxt  = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else begin
         if (w_mark_dirty) r_dirty[w_idx] <= 1'b1;
         if (w_fill) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
         end
      end
   end

   // Storage and request capture carry no reset; validity bits guard them.
   always_ff @(posedge clk) begin
      if (reset && w_we) r_data[w_widx] <= w_wdata;
      if (reset && w_fill) r_tag[w_idx] <= w_tag;
      if (r_state == S_IDLE && cpu_req) begin
         r_waddr <= address_input[ADDR_W-1:2];
         r_we    <= write_en_in;
         r_wdata <= read_data_2;
      end
   end

`ifdef CACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (cache_done) begin
         if (hit) hit_count  <= hit_count + 32'd1;
         else     miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_wb_param.sv
// Self-checking bench for cache_wb_param: flat-memory reference plus
// a line-level cache model predicting hits, bursts and load data.
module tb_cache_wb_param;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_req = 1'b0;
   logic        write_en_in = 1'b0;
   logic [31:0] address_input = '0;
   logic [31:0] read_data_2 = '0;
   logic        cpu_ready;
   logic [31:0] read_data;
   logic        hit;
   logic        cache_done;
   logic        mem_req;
   logic        write_en_out;
   logic [31:0] address_output;
   logic [31:0] mem_data_in;
   logic [31:0] mem_data_out = '0;
   logic        mem_ready = 1'b1;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   always #5 clk = ~clk;

   cache_wb_param #(
      .ADDR_W(32), .DATA_W(32), .LINES(256), .WORDS_PER_LINE(4)
   ) dut (
      .clk(clk), .reset(reset), .cpu_req(cpu_req),
      .write_en_in(write_en_in), .address_input(address_input),
      .read_data_2(read_data_2), .cpu_ready(cpu_ready),
      .read_data(read_data), .hit(hit), .cache_done(cache_done),
      .mem_req(mem_req), .write_en_out(write_en_out),
      .address_output(address_output), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out),
`ifdef CACHE_STATS_EN
      .hit_count(hit_count), .miss_count(miss_count),
`endif
      .mem_ready(mem_ready)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] a;
      logic [31:0] d;
   } beat_t;

   typedef struct packed {
      logic        hit;
      logic        we;
      logic [31:0] d;
   } resp_t;

   int          total = 0;
   int          passed = 0;
   bit          run = 0;
   logic [31:0] bk      [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];
   beat_t       exp_beats[$];
   beat_t       log_beats[$];
   resp_t       exp_resp[$];
   logic        mvalid [256];
   logic        mdirty [256];
   logic [19:0] mtag   [256];

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   task automatic fail_now(input string nm);
      total++;
      $display("FAIL %s: got timeout/empty expected event", nm);
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return 32'hC0DE0000 | {16'h0, a[15:0]};
   endfunction

   function automatic logic [31:0] bk_rd(input logic [31:0] a);
      return bk.exists(a) ? bk[a] : dflt(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   task automatic predict(input logic we, input logic [31:0] a,
                          input logic [31:0] d);
      logic [7:0]  idx;
      logic [19:0] tag;
      logic [31:0] ba;
      logic        h;
      resp_t       r;
      idx = a[11:4];
      tag = a[31:12];
      h   = mvalid[idx] && (mtag[idx] == tag);
      if (!h) begin
         if (mvalid[idx] && mdirty[idx])
            for (int b = 0; b < 4; b++) begin
               ba = {mtag[idx], idx, 2'(b), 2'b00};
               exp_beats.push_back('{1'b1, ba, ref_rd(ba)});
            end
         for (int b = 0; b < 4; b++)
            exp_beats.push_back('{1'b0, {tag, idx, 2'(b), 2'b00}, 32'h0});
         mvalid[idx] = 1'b1;
         mdirty[idx] = 1'b0;
         mtag[idx]   = tag;
      end
      if (we) begin
         ref_mem[{a[31:2], 2'b00}] = d;
         mdirty[idx] = 1'b1;
      end
      r.hit = h;
      r.we  = we;
      r.d   = ref_rd({a[31:2], 2'b00});
      exp_resp.push_back(r);
   endtask

   task automatic model_reset();
      exp_beats.delete();
      exp_resp.delete();
      for (int i = 0; i < 256; i++) begin
         mvalid[i] = 1'b0;
         mdirty[i] = 1'b0;
      end
      ref_mem = bk;
   endtask

   always @(posedge clk) begin
      #1;
      mem_data_out = bk_rd(address_output);
   end

   logic        hold_v = 1'b0;
   logic [31:0] hold_a, hold_d;
   always @(negedge clk) begin
      beat_t e;
      resp_t r;
      if (run) begin
         if (mem_req) begin
            if (hold_v) begin
               chk("stall_addr", address_output, hold_a);
               chk("stall_data", mem_data_in, hold_d);
            end
            if (mem_ready) begin
               log_beats.push_back('{write_en_out, address_output, mem_data_in});
               if (exp_beats.size() == 0) fail_now("unexpected_beat");
               else begin
                  e = exp_beats.pop_front();
                  chk("beat_dir", {31'h0, write_en_out}, {31'h0, e.we});
                  chk("beat_addr", address_output, e.a);
                  if (e.we) chk("wb_data", mem_data_in, e.d);
               end
               if (write_en_out) bk[address_output] = mem_data_in;
            end
            hold_v = !mem_ready;
            hold_a = address_output;
            hold_d = mem_data_in;
         end else begin
            hold_v = 1'b0;
         end
         if (cache_done) begin
            if (exp_resp.size() == 0) fail_now("unexpected_done");
            else begin
               r = exp_resp.pop_front();
               chk("resp_hit", {31'h0, hit}, {31'h0, r.hit});
               if (!r.we) chk("resp_data", read_data, r.d);
            end
         end
      end
   end

   task automatic issue(input logic we, input logic [31:0] a,
                        input logic [31:0] d);
      int n = 0;
      @(posedge clk); #1;
      while (!cpu_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!cpu_ready) fail_now("cpu_ready_wait");
      cpu_req       = 1'b1;
      write_en_in   = we;
      address_input = a;
      read_data_2   = d;
      predict(we, a, d);
      @(posedge clk); #1;
      cpu_req = 1'b0;
   endtask

   task automatic wait_done(output int lat, output bit seen,
                            output logic h, output logic [31:0] rd);
      lat  = 0;
      seen = 0;
      h    = 1'b0;
      rd   = '0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (mem_req) seen = 1;
         if (cache_done) begin
            lat = i;
            h   = hit;
            rd  = read_data;
            break;
         end
      end
      if (lat == 0) fail_now("done_timeout");
   endtask

   task automatic acc(input logic we, input logic [31:0] a,
                      input logic [31:0] d, output int lat,
                      output bit seen, output logic h,
                      output logic [31:0] rd);
      issue(we, a, d);
      wait_done(lat, seen, h, rd);
   endtask

   initial begin
      int          lat;
      bit          seen;
      logic        h;
      logic [31:0] rd;
      bit          found;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      run = 1;
      @(negedge clk);
      chk("rst_cpu_ready", {31'h0, cpu_ready}, 32'h1);
      chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("rst_done", {31'h0, cache_done}, 32'h0);
      chk("rst_hit", {31'h0, hit}, 32'h0);
      chk("rst_addr_out", address_output, 32'h0);
`ifdef CACHE_STATS_EN
      chk("rst_hit_count", hit_count, 32'h0);
      chk("rst_miss_count", miss_count, 32'h0);
`endif

      log_beats.delete();
      acc(1'b0, 32'h40, 32'h0, lat, seen, h, rd);
      chk("s1_hit", {31'h0, h}, 32'h0);
      chk("s1_data", rd, 32'hC0DE0040);
      chk("s1_beats", 32'(log_beats.size()), 32'd4);
      if (log_beats.size() == 4) begin
         chk("s1_b0", log_beats[0].a, 32'h40);
         chk("s1_b3", log_beats[3].a, 32'h4C);
      end

      acc(1'b0, 32'h44, 32'h0, lat, seen, h, rd);
      chk("s2_lat", 32'(lat), 32'd1);
      chk("s2_mem", {31'h0, seen}, 32'h0);
      chk("s2_hit", {31'h0, h}, 32'h1);
      chk("s2_data", rd, 32'hC0DE0044);

      acc(1'b1, 32'h48, 32'hDEADBEEF, lat, seen, h, rd);
      chk("s3_st_lat", 32'(lat), 32'd1);
      chk("s3_st_hit", {31'h0, h}, 32'h1);
      log_beats.delete();
      acc(1'b0, 32'h1048, 32'h0, lat, seen, h, rd);
      chk("s3_hit", {31'h0, h}, 32'h0);
      chk("s3_data", rd, 32'hC0DE1048);
      chk("s3_beats", 32'(log_beats.size()), 32'd8);
      if (log_beats.size() == 8) begin
         chk("s3_wb0_addr", log_beats[0].a, 32'h40);
         chk("s3_wb0_we", {31'h0, log_beats[0].we}, 32'h1);
         chk("s3_wb2_data", log_beats[2].d, 32'hDEADBEEF);
         chk("s3_rf0_addr", log_beats[4].a, 32'h1040);
         chk("s3_rf3_addr", log_beats[7].a, 32'h104C);
      end
`ifdef CACHE_STATS_EN
      chk("s3_hit_count", hit_count, 32'd2);
      chk("s3_miss_count", miss_count, 32'd2);
`endif

      acc(1'b0, 32'h48, 32'h0, lat, seen, h, rd);
      chk("wb_back_data", rd, 32'hDEADBEEF);
      acc(1'b1, 32'h84, 32'h12345678, lat, seen, h, rd);
      chk("stmiss_hit", {31'h0, h}, 32'h0);
      acc(1'b0, 32'h84, 32'h0, lat, seen, h, rd);
      chk("stmiss_rd", rd, 32'h12345678);
      acc(1'b0, 32'h1084, 32'h0, lat, seen, h, rd);
      chk("evict_rd", rd, 32'hC0DE1084);

      issue(1'b0, 32'h2040, 32'h0);
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (mem_req && !write_en_out && address_output[3:2] == 2'd1)
            found = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      if (!found) fail_now("stall_beat_wait");
      mem_ready = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         chk("s4_req", {31'h0, mem_req}, 32'h1);
         chk("s4_addr", address_output, 32'h2044);
      end
      mem_ready = 1'b1;
      wait_done(lat, seen, h, rd);
      chk("s4_data", rd, 32'hC0DE2040);

      issue(1'b0, 32'h1040, 32'h0);
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (mem_req && address_output == 32'h1048) found = 1;
         else begin
            @(posedge clk); #1;
         end
      end
      if (!found) fail_now("reset_beat_wait");
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      chk("s5_req", {31'h0, mem_req}, 32'h0);
      chk("s5_ready", {31'h0, cpu_ready}, 32'h1);
      log_beats.delete();
      acc(1'b0, 32'h1040, 32'h0, lat, seen, h, rd);
      chk("s5_hit", {31'h0, h}, 32'h0);
      chk("s5_data", rd, 32'hC0DE1040);
      chk("s5_beats", 32'(log_beats.size()), 32'd4);
`ifdef CACHE_STATS_EN
      chk("s5_hit_count", hit_count, 32'd0);
      chk("s5_miss_count", miss_count, 32'd1);
`endif

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
